// File: rtl/sync_data_change_capture.sv
// Slow-domain change-capture queue: each change on syncData becomes one event on a valid/ready stream.
// Optional SYNC_CAPTURE_TIMESTAMP_EN adds a free-running tsCounter and a per-entry outTimestamp.
module sync_data_change_capture #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  sinkClock,
    input  logic                  sinkResetN,
    input  logic [DATA_WIDTH-1:0] syncData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    input  logic                  clearOverflow,
    output logic                  overflow,
    output logic [7:0]            dropCount
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
    ,
    output logic [15:0]           outTimestamp
`endif
);

    localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountWidth = PtrWidth + 1;
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] lastDataQ;
    logic [DATA_WIDTH-1:0] dataMemQ [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] holdDataQ, holdDataD;
    logic [PtrWidth-1:0]   wrPtrQ, wrPtrD;
    logic [PtrWidth-1:0]   rdPtrQ, rdPtrD;
    logic [CountWidth-1:0] countQ, countD;
    logic                  overflowQ, overflowD;
    logic [7:0]            dropCountQ, dropCountD;

    logic changeEvent;
    logic isFull;
    logic pushEn;
    logic popEn;
    logic dropEn;

    always_comb begin
        changeEvent = (syncData != lastDataQ);
        isFull      = (countQ == FullCount);
        popEn       = outValid && outReady;
        // A pop frees the slot in the same cycle, so a full queue still accepts the event.
        pushEn      = changeEvent && (!isFull || popEn);
        dropEn      = changeEvent && isFull && !popEn;
    end

    always_comb begin
        wrPtrD    = wrPtrQ;
        rdPtrD    = rdPtrQ;
        countD    = countQ;
        holdDataD = holdDataQ;
        if (pushEn) begin
            wrPtrD = wrPtrQ + PtrWidth'(1);
        end
        if (popEn) begin
            rdPtrD    = rdPtrQ + PtrWidth'(1);
            holdDataD = dataMemQ[rdPtrQ];
        end
        unique case ({pushEn, popEn})
            2'b10:   countD = countQ + CountWidth'(1);
            2'b01:   countD = countQ - CountWidth'(1);
            default: countD = countQ;
        endcase
    end

    always_comb begin
        overflowD  = overflowQ;
        dropCountD = dropCountQ;
        if (dropEn) begin
            overflowD = 1'b1;
            if (clearOverflow) begin
                dropCountD = 8'd1;
            end else if (dropCountQ != 8'hFF) begin
                dropCountD = dropCountQ + 8'd1;
            end
        end else if (clearOverflow) begin
            overflowD  = 1'b0;
            dropCountD = 8'd0;
        end
    end

    always_ff @(posedge sinkClock or negedge sinkResetN) begin
        if (!sinkResetN) begin
            lastDataQ  <= '0;
            holdDataQ  <= '0;
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            dropCountQ <= 8'd0;
        end else begin
            lastDataQ  <= syncData;
            holdDataQ  <= holdDataD;
            wrPtrQ     <= wrPtrD;
            rdPtrQ     <= rdPtrD;
            countQ     <= countD;
            overflowQ  <= overflowD;
            dropCountQ <= dropCountD;
        end
    end

    always_ff @(posedge sinkClock or negedge sinkResetN) begin
        if (!sinkResetN) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                dataMemQ[i] <= '0;
            end
        end else if (pushEn) begin
            dataMemQ[wrPtrQ] <= syncData;
        end
    end

    // Empty queue shows the last popped value rather than stale storage.
    always_comb begin
        outValid  = (countQ != '0);
        outData   = outValid ? dataMemQ[rdPtrQ] : holdDataQ;
        overflow  = overflowQ;
        dropCount = dropCountQ;
    end

`ifdef SYNC_CAPTURE_TIMESTAMP_EN
    logic [15:0] tsCounterQ;
    logic [15:0] tsMemQ [FIFO_DEPTH];
    logic [15:0] holdTsQ;

    always_ff @(posedge sinkClock or negedge sinkResetN) begin
        if (!sinkResetN) begin
            tsCounterQ <= 16'd0;
            holdTsQ    <= 16'd0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                tsMemQ[i] <= 16'd0;
            end
        end else begin
            tsCounterQ <= tsCounterQ + 16'd1;
            if (pushEn) begin
                tsMemQ[wrPtrQ] <= tsCounterQ;
            end
            if (popEn) begin
                holdTsQ <= tsMemQ[rdPtrQ];
            end
        end
    end

    always_comb begin
        outTimestamp = outValid ? tsMemQ[rdPtrQ] : holdTsQ;
    end
`endif

endmodule

// File: tb/tb_sync_data_change_capture.sv
// Directed bench for sync_data_change_capture; inputs change on the falling edge, outputs
// are sampled on the falling edge as well.
module tb_sync_data_change_capture;

    logic       sinkClock = 1'b0;
    logic       sinkResetN;
    logic [7:0] syncData;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic       clearOverflow;
    logic       overflow;
    logic [7:0] dropCount;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SYNC_CAPTURE_TIMESTAMP_EN
    logic [15:0] outTimestamp;
    logic [15:0] tbTs;
    logic [15:0] tsExp [5];

    always @(posedge sinkClock or negedge sinkResetN) begin
        if (!sinkResetN) tbTs <= 16'd0;
        else             tbTs <= tbTs + 16'd1;
    end
`endif

    sync_data_change_capture #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .sinkClock     (sinkClock),
        .sinkResetN    (sinkResetN),
        .syncData      (syncData),
        .outValid      (outValid),
        .outReady      (outReady),
        .outData       (outData),
        .clearOverflow (clearOverflow),
        .overflow      (overflow),
        .dropCount     (dropCount)
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        ,
        .outTimestamp  (outTimestamp)
`endif
    );

    always #5 sinkClock = ~sinkClock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge sinkClock);
    endtask

    initial begin
        sinkResetN    = 1'b0;
        syncData      = 8'h00;
        outReady      = 1'b0;
        clearOverflow = 1'b0;
        #2;
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_data", {24'd0, outData}, 32'h00);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drops", {24'd0, dropCount}, 32'd0);
        tick();
        sinkResetN = 1'b1;

        // Test 1: constant zero produces no events
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_valid", {31'd0, outValid}, 32'd0);
        end
        check("idle_ovf", {31'd0, overflow}, 32'd0);
        check("idle_drops", {24'd0, dropCount}, 32'd0);

        // Test 2: single change, one-cycle valid with outReady held
        outReady = 1'b1;
        syncData = 8'hA5;
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        tsExp[0] = tbTs;
`endif
        check("t2_pre_valid", {31'd0, outValid}, 32'd0);
        tick();
        check("t2_valid", {31'd0, outValid}, 32'd1);
        check("t2_data", {24'd0, outData}, 32'hA5);
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        check("t2_ts", {16'd0, outTimestamp}, {16'd0, tsExp[0]});
`endif
        tick();
        check("t2_valid_gone", {31'd0, outValid}, 32'd0);
        check("t2_hold_data", {24'd0, outData}, 32'hA5);

        // Test 3: six changes into a four-entry queue with no consumer
        outReady = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            syncData = 8'(i);
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
            if (i <= 4) tsExp[i-1] = tbTs;
`endif
            tick();
        end
        check("t3_valid", {31'd0, outValid}, 32'd1);
        check("t3_head", {24'd0, outData}, 32'h01);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_drops", {24'd0, dropCount}, 32'd2);
        tick();
        check("t3_head_stable", {24'd0, outData}, 32'h01);
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        check("t3_ts0", {16'd0, outTimestamp}, {16'd0, tsExp[0]});
`endif

        // Test 4: full queue, pop and new value in the same cycle
        outReady = 1'b1;
        syncData = 8'h77;
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        tsExp[4] = tbTs;
`endif
        tick();
        check("t4_data1", {24'd0, outData}, 32'h02);
        check("t4_no_drop", {24'd0, dropCount}, 32'd2);
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        check("t4_ts1", {16'd0, outTimestamp}, {16'd0, tsExp[1]});
`endif
        tick();
        check("t4_data2", {24'd0, outData}, 32'h03);
        tick();
        check("t4_data3", {24'd0, outData}, 32'h04);
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        check("t4_ts3", {16'd0, outTimestamp}, {16'd0, tsExp[3]});
`endif
        tick();
        check("t4_last_valid", {31'd0, outValid}, 32'd1);
        check("t4_last", {24'd0, outData}, 32'h77);
`ifdef SYNC_CAPTURE_TIMESTAMP_EN
        check("t4_ts77", {16'd0, outTimestamp}, {16'd0, tsExp[4]});
`endif
        tick();
        check("t4_empty", {31'd0, outValid}, 32'd0);
        check("t4_hold", {24'd0, outData}, 32'h77);

        // Test 5: 4 fills + 300 drops saturate dropCount, then clear
        outReady = 1'b0;
        for (int i = 0; i < 304; i++) begin
            syncData = 8'(i + 1);
            tick();
        end
        check("t5_sat", {24'd0, dropCount}, 32'd255);
        check("t5_ovf", {31'd0, overflow}, 32'd1);
        check("t5_head", {24'd0, outData}, 32'h01);
        clearOverflow = 1'b1;
        tick();
        check("t5_clr_ovf", {31'd0, overflow}, 32'd0);
        check("t5_clr_drops", {24'd0, dropCount}, 32'd0);
        syncData = 8'h99;
        tick();
        check("t5_win_ovf", {31'd0, overflow}, 32'd1);
        check("t5_win_drops", {24'd0, dropCount}, 32'd1);
        tick();
        check("t5_clr2_drops", {24'd0, dropCount}, 32'd0);
        clearOverflow = 1'b0;

        // Test 6: asynchronous reset with three entries queued
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check("t6_head", {24'd0, outData}, 32'h02);
        #2;
        sinkResetN = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, outValid}, 32'd0);
        check("t6_async_data", {24'd0, outData}, 32'h00);
        check("t6_async_ovf", {31'd0, overflow}, 32'd0);
        syncData = 8'h00;
        tick();
        sinkResetN = 1'b1;
        tick();
        check("t6_quiet", {31'd0, outValid}, 32'd0);
        syncData = 8'h3C;
        tick();
        check("t6_first_valid", {31'd0, outValid}, 32'd1);
        check("t6_first_data", {24'd0, outData}, 32'h3C);

        // outReady while empty must not move pointers
        outReady = 1'b1;
        tick();
        tick();
        tick();
        check("t7_empty", {31'd0, outValid}, 32'd0);
        outReady = 1'b0;
        syncData = 8'h11;
        tick();
        syncData = 8'h22;
        tick();
        check("t7_head", {24'd0, outData}, 32'h11);
        outReady = 1'b1;
        tick();
        check("t7_next", {24'd0, outData}, 32'h22);
        tick();
        check("t7_drained", {31'd0, outValid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
